// File: rtl/full_adder_data.sv
// rtl/full_adder_data.sv - 1-bit full adder with registered result, valid strobe and optional statistics counters
// Optional feature macro: FULL_ADDER_DATA_STATS_EN (saturating op/carry counters with synchronous clear)
module full_adder_data #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             en,
    input  logic             clr,
    output logic             Sum,
    output logic             Carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] carry_cnt,
    output logic [CNT_W-1:0] op_cnt
);

    always_comb begin
        Sum   = a ^ b ^ c;
        Carry = (a & b) | (b & c) | (a & c);
    end

    // Result capture: clr deliberately has no effect here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                sum_q   <= Sum;
                carry_q <= Carry;
            end
        end
    end

`ifdef FULL_ADDER_DATA_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt    <= '0;
            carry_cnt <= '0;
        end else if (clr) begin
            op_cnt    <= '0;
            carry_cnt <= '0;
        end else if (en) begin
            if (op_cnt != CNT_MAX) begin
                op_cnt <= op_cnt + CNT_ONE;
            end
            if (Carry && (carry_cnt != CNT_MAX)) begin
                carry_cnt <= carry_cnt + CNT_ONE;
            end
        end
    end
`else
    logic unused_clr;

    assign unused_clr = clr;
    assign op_cnt     = '0;
    assign carry_cnt  = '0;
`endif

endmodule

// File: tb/tb_full_adder_data.sv
// tb/tb_full_adder_data.sv - scoreboard bench for full_adder_data with random stimulus and arithmetic reference model
module tb_full_adder_data;

    localparam int CNT_W = 8;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic             c = 1'b0;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic             Sum;
    logic             Carry;
    logic             sum_q;
    logic             carry_q;
    logic             valid_q;
    logic [CNT_W-1:0] carry_cnt;
    logic [CNT_W-1:0] op_cnt;

    int total = 0;
    int bad = 0;

    full_adder_data #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .en(en), .clr(clr),
        .Sum(Sum), .Carry(Carry), .sum_q(sum_q), .carry_q(carry_q),
        .valid_q(valid_q), .carry_cnt(carry_cnt), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state, advanced once per rising edge.
    int          exp_q[$];
    int          exp_valid = 0;
    int          last_val = 0;
    longint      exp_op = 0;
    longint      exp_carry = 0;
    bit          stats_en;

    initial begin
`ifdef FULL_ADDER_DATA_STATS_EN
        stats_en = 1'b1;
`else
        stats_en = 1'b0;
`endif
    end

    always @(posedge clk) begin
        int s;
        s = int'(a) + int'(b) + int'(c);
        if (!rst_n) begin
            exp_q.delete();
            exp_valid = 0;
            last_val  = 0;
            exp_op    = 0;
            exp_carry = 0;
        end else begin
            exp_valid = en ? 1 : 0;
            if (en) exp_q.push_back(s);
            if (stats_en) begin
                if (clr) begin
                    exp_op    = 0;
                    exp_carry = 0;
                end else if (en) begin
                    if (exp_op < CNT_MAX) exp_op = exp_op + 1;
                    if (s >= 2 && exp_carry < CNT_MAX) exp_carry = exp_carry + 1;
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: away from the rising edge, pop and compare whenever valid_q is presented.
    always @(negedge clk) begin
        int got;
        got = {30'd0, carry_q, sum_q};
        check("valid_q", longint'(valid_q), longint'(exp_valid));
        if (valid_q === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result_pop: got %0d expected none (queue empty) at %0t", got, $time);
            end else begin
                last_val = exp_q.pop_front();
                check("result", longint'(got), longint'(last_val));
            end
        end else begin
            check("hold", longint'(got), longint'(last_val));
        end
        check("op_cnt", longint'(op_cnt), exp_op);
        check("carry_cnt", longint'(carry_cnt), exp_carry);
    end

    task automatic check_comb();
        #1;
        check("comb_sum_carry", longint'({Carry, Sum}), longint'(int'(a) + int'(b) + int'(c)));
    endtask

    // Called one time unit after a rising edge; applies inputs for the next edge.
    task automatic cycle(input logic [2:0] abc, input logic ien, input logic iclr, input logic irst);
        {a, b, c} = abc;
        en    = ien;
        clr   = iclr;
        rst_n = irst;
        check_comb();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Combinational sweep while held in reset, 10 time units per code.
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            check_comb();
            #9;
        end
        @(posedge clk);
        #1;

        // Reset edge, single capture of 1+1+0, then hold.
        cycle(3'b000, 1'b0, 1'b0, 1'b0);
        cycle(3'b110, 1'b1, 1'b0, 1'b1);
        cycle(3'b111, 1'b0, 1'b0, 1'b1);
        cycle(3'b001, 1'b0, 1'b0, 1'b1);

        // Clear, then eight continuous captures over all codes.
        cycle(3'b000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(3'(i), 1'b1, 1'b0, 1'b1);
        cycle(3'b000, 1'b0, 1'b0, 1'b1);
        if (stats_en) begin
            check("op_cnt_sweep", longint'(op_cnt), 8);
            check("carry_cnt_sweep", longint'(carry_cnt), 4);
        end

        // Reset asserted mid-cycle must not act before the edge; concurrent capture discarded.
        cycle(3'b011, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        en    = 1'b1;
        {a, b, c} = 3'b111;
        #2;
        check("async_rst_no_effect", longint'({carry_q, sum_q}), 2);
        @(posedge clk);
        #1;
        check("rst_clears", longint'({valid_q, carry_q, sum_q}), 0);
        cycle(3'b101, 1'b1, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) != 0));
        end

        // Saturation with all-ones operands, then clr beating a simultaneous capture.
        cycle(3'b000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 270; i++) cycle(3'b111, 1'b1, 1'b0, 1'b1);
        if (stats_en) begin
            check("op_cnt_sat", longint'(op_cnt), CNT_MAX);
            check("carry_cnt_sat", longint'(carry_cnt), CNT_MAX);
        end
        cycle(3'b111, 1'b1, 1'b1, 1'b1);
        check("clr_priority_op", longint'(op_cnt), 0);
        check("clr_priority_carry", longint'(carry_cnt), 0);

        cycle(3'b000, 1'b0, 1'b0, 1'b1);
        cycle(3'b000, 1'b0, 1'b0, 1'b1);
        check("queue_drained", longint'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_adder_data.md
FULL_ADDER_DATA -- requirements
Module: full_adder_data

Interface
REQ-001 Parameter CNT_W, default 8: width of statistics counters, legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 a  input  1  addend bit A.
REQ-005 b  input  1  addend bit B.
REQ-006 c  input  1  carry-in bit.
REQ-007 en  input  1  capture enable; registers operands' result when high.
REQ-008 clr  input  1  synchronous clear of statistics counters.
REQ-009 Sum  output  1  combinational sum bit.
REQ-010 Carry  output  1  combinational carry-out bit.
REQ-011 sum_q  output  1  registered sum.
REQ-012 carry_q  output  1  registered carry.
REQ-013 valid_q  output  1  high for the cycle after each captured result.
REQ-014 carry_cnt  output  CNT_W  count of captured results with carry=1.
REQ-015 op_cnt  output  CNT_W  count of captured operations.

Function
REQ-016 Sum SHALL equal a XOR b XOR c, purely combinational, independent of clk, rst_n, en.
REQ-017 Carry SHALL equal (a AND b) OR (b AND c) OR (a AND c), purely combinational.
REQ-018 Sum/Carry together SHALL equal the 2-bit value a+b+c for all 8 input combinations; no X for known inputs.
REQ-019 On rising clk with rst_n=1, en=1: sum_q<=Sum, carry_q<=Carry; latency exactly 1 cycle.
REQ-020 With en=0, sum_q and carry_q SHALL hold their values.
REQ-021 valid_q SHALL register en each cycle (valid_q=1 exactly one cycle per en=1 cycle; continuous en gives continuous valid_q).
REQ-022 op_cnt SHALL increment by 1 on each en=1 cycle; saturate at 2^CNT_W-1, no wrap.
REQ-023 carry_cnt SHALL increment by 1 on each en=1 cycle where Carry=1; saturate at 2^CNT_W-1, no wrap.
REQ-024 clr=1 SHALL zero both counters next edge; clr has priority over simultaneous increment; sum_q/carry_q/valid_q unaffected by clr.
REQ-025 Priority per edge: rst_n low > clr > en-driven update > hold.

Reset
REQ-026 rst_n=0 at a rising edge SHALL set sum_q=0, carry_q=0, valid_q=0, carry_cnt=0, op_cnt=0.
REQ-027 Reset SHALL be synchronous only; asserting rst_n between edges SHALL not change registered outputs until next edge.
REQ-028 Reset mid-operation SHALL discard the concurrent en capture; Sum/Carry continue tracking inputs during reset.
REQ-029 After rst_n returns high, first en=1 edge SHALL capture normally with no extra latency.

Configuration
REQ-030 Macro FULL_ADDER_DATA_STATS_EN: when defined, counters and clr per REQ-022..024 are implemented.
REQ-031 When FULL_ADDER_DATA_STATS_EN is undefined, carry_cnt and op_cnt SHALL be constant 0, clr ignored, port list unchanged; all other behaviour identical.

Verification
REQ-032 Sweep {a,b,c}=0..7, 10 time units each -> {Carry,Sum}=00,01,01,10,01,10,10,11 combinationally, including while rst_n=0.
REQ-033 rst_n=0 one edge then en=1 with a=1,b=1,c=0 -> next edge sum_q=0, carry_q=1, valid_q=1; en=0 next -> valid_q=0, sum_q/carry_q held.
REQ-034 en=1 for 8 cycles sweeping 0..7 -> op_cnt=8, carry_cnt=4 (STATS_EN defined).
REQ-035 CNT_W=2, en=1 with a=b=c=1 for 6 cycles -> op_cnt=3, carry_cnt=3 held (saturation); clr=1 with en=1 -> both 0 next edge.
REQ-036 rst_n=0 coincident with en=1 and clr=0 -> all registered outputs 0 next edge; build without FULL_ADDER_DATA_STATS_EN -> counters stay 0 throughout.
